// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory port, aligns byte/half lanes,
// extends loads, selects the write-back value and stalls EX/MEM while an access is outstanding.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        MemRead_In,
    input  logic        MemWrite_In,
    input  logic [1:0]  ByteSel_In,
    input  logic [1:0]  MemToReg_In,
    input  logic        RegWrite_In,
    input  logic [4:0]  RegDest_In,
    input  logic [31:0] ALUResult_In,
    input  logic [31:0] WriteData_In,
    input  logic [31:0] PCI_In,
    output logic        DMemReq,
    output logic        DMemWE,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    output logic [3:0]  DMemByteEn,
    input  logic        DMemAck,
    input  logic [31:0] DMemRData,
    output logic        Stall_Out,
    output logic        RegWrite_Out,
    output logic [4:0]  RegDest_Out,
    output logic [31:0] WBData_Out,
    output logic        MisAlign_Out,
    output logic        BusErr_Out
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic        w_memop, w_store, w_mis, w_timeout;
    logic [1:0]  w_a;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata, w_ldata, w_wb;

    assign w_a       = ALUResult_In[1:0];
    assign w_memop   = MemRead_In | MemWrite_In;
    assign w_store   = MemWrite_In;
    assign w_mis     = ((ByteSel_In == 2'b01) && w_a[0]) || ((ByteSel_In == 2'b00) && (w_a != 2'b00));
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

    // Upstream inputs are held while stalled, so the WAIT state reads them directly.
    assign Stall_Out = (r_state == S_IDLE) ? (w_memop && !w_mis) : (!DMemAck && !w_timeout);

    always_comb begin
        w_byte = DMemRData[7:0];
        case (w_a)
            2'b01:   w_byte = DMemRData[15:8];
            2'b10:   w_byte = DMemRData[23:16];
            2'b11:   w_byte = DMemRData[31:24];
            default: w_byte = DMemRData[7:0];
        endcase
        w_half = w_a[1] ? DMemRData[31:16] : DMemRData[15:0];
        case (ByteSel_In)
            2'b00: begin
                w_ldata  = DMemRData;
                w_wdata  = WriteData_In;
                w_byteen = 4'b1111;
            end
            2'b01: begin
                w_ldata  = {{16{w_half[15]}}, w_half};
                w_wdata  = {2{WriteData_In[15:0]}};
                w_byteen = w_a[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_ldata  = {{24{w_byte[7]}}, w_byte};
                w_wdata  = {4{WriteData_In[7:0]}};
                w_byteen = 4'b0001 << w_a;
            end
            default: begin
                w_ldata  = {24'b0, w_byte};
                w_wdata  = {4{WriteData_In[7:0]}};
                w_byteen = 4'b0001 << w_a;
            end
        endcase
        case (MemToReg_In)
            2'b01:   w_wb = w_ldata;
            2'b10:   w_wb = PCI_In;
            default: w_wb = ALUResult_In;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            DMemReq      <= 1'b0;
            DMemWE       <= 1'b0;
            DMemAddr     <= '0;
            DMemWData    <= '0;
            DMemByteEn   <= '0;
            RegWrite_Out <= 1'b0;
            RegDest_Out  <= '0;
            WBData_Out   <= '0;
            MisAlign_Out <= 1'b0;
            BusErr_Out   <= 1'b0;
        end else begin
            MisAlign_Out <= 1'b0;
            BusErr_Out   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_memop && w_mis) begin
                        MisAlign_Out <= 1'b1;
                        RegWrite_Out <= 1'b0;
                        RegDest_Out  <= RegDest_In;
                        WBData_Out   <= w_wb;
                    end else if (w_memop) begin
                        r_state      <= S_WAIT;
                        r_cnt        <= '0;
                        DMemReq      <= 1'b1;
                        DMemWE       <= w_store;
                        DMemAddr     <= {ALUResult_In[31:2], 2'b00};
                        DMemWData    <= w_wdata;
                        DMemByteEn   <= w_byteen;
                        // Bubble into MEM/WB while the access is outstanding.
                        RegWrite_Out <= 1'b0;
                    end else begin
                        RegWrite_Out <= RegWrite_In;
                        RegDest_Out  <= RegDest_In;
                        WBData_Out   <= w_wb;
                    end
                end
                S_WAIT: begin
                    if (DMemAck) begin
                        r_state      <= S_IDLE;
                        DMemReq      <= 1'b0;
                        RegWrite_Out <= RegWrite_In && !w_store;
                        RegDest_Out  <= RegDest_In;
                        WBData_Out   <= w_wb;
                    end else if (w_timeout) begin
                        r_state      <= S_IDLE;
                        DMemReq      <= 1'b0;
                        BusErr_Out   <= 1'b1;
                        RegWrite_Out <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: reset, ALU pass-through, loads, stores,
// misalignment, timeout and reset during an outstanding access.
module tb_mem_access_stage;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        MemRead_In, MemWrite_In, RegWrite_In;
    logic [1:0]  ByteSel_In, MemToReg_In;
    logic [4:0]  RegDest_In;
    logic [31:0] ALUResult_In, WriteData_In, PCI_In;
    logic        DMemReq, DMemWE, DMemAck;
    logic [31:0] DMemAddr, DMemWData, DMemRData;
    logic [3:0]  DMemByteEn;
    logic        Stall_Out, RegWrite_Out, MisAlign_Out, BusErr_Out;
    logic [4:0]  RegDest_Out;
    logic [31:0] WBData_Out;

    int n_chk = 0;
    int n_err = 0;
    int n_stall;

    mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .Clock(Clock), .Reset(Reset),
        .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
        .ByteSel_In(ByteSel_In), .MemToReg_In(MemToReg_In),
        .RegWrite_In(RegWrite_In), .RegDest_In(RegDest_In),
        .ALUResult_In(ALUResult_In), .WriteData_In(WriteData_In), .PCI_In(PCI_In),
        .DMemReq(DMemReq), .DMemWE(DMemWE), .DMemAddr(DMemAddr),
        .DMemWData(DMemWData), .DMemByteEn(DMemByteEn),
        .DMemAck(DMemAck), .DMemRData(DMemRData),
        .Stall_Out(Stall_Out), .RegWrite_Out(RegWrite_Out), .RegDest_Out(RegDest_Out),
        .WBData_Out(WBData_Out), .MisAlign_Out(MisAlign_Out), .BusErr_Out(BusErr_Out)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_in();
        MemRead_In = 0; MemWrite_In = 0; ByteSel_In = 0; MemToReg_In = 0;
        RegWrite_In = 0; RegDest_In = 0; ALUResult_In = 0; WriteData_In = 0; PCI_In = 0;
        DMemAck = 0; DMemRData = 0;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic [1:0] m2r,
                      input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] wd);
        MemRead_In = rd; MemWrite_In = wr; ByteSel_In = sz; MemToReg_In = m2r;
        RegWrite_In = 1; RegDest_In = dst; ALUResult_In = alu; WriteData_In = wd;
        #1;
    endtask

    // Issue a load, ack it in the first WAIT cycle, and check the extended result.
    task automatic quick_load(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic [31:0] exp);
        op(1, 0, sz, 2'b01, 5'd9, addr, 32'h0);
        tick();
        DMemAck = 1; DMemRData = rdata;
        tick();
        idle_in();
        chk({tag, "_wb"}, WBData_Out, exp);
    endtask

    initial begin
        idle_in();
        Reset = 0;
        tick(); tick();
        Reset = 1;
        chk("rst_req", {31'b0, DMemReq}, 0);
        chk("rst_addr", DMemAddr, 0);
        chk("rst_wb", WBData_Out, 0);
        chk("rst_rw", {31'b0, RegWrite_Out}, 0);
        chk("rst_stall", {31'b0, Stall_Out}, 0);

        // ALU pass-through and the other write-back sources
        op(0, 0, 2'b00, 2'b00, 5'd7, 32'h1234, 32'h0);
        chk("alu_stall", {31'b0, Stall_Out}, 0);
        tick();
        chk("alu_wb", WBData_Out, 32'h1234);
        chk("alu_dst", {27'b0, RegDest_Out}, 7);
        chk("alu_rw", {31'b0, RegWrite_Out}, 1);
        chk("alu_stall2", {31'b0, Stall_Out}, 0);
        PCI_In = 32'hDEAD_0004; MemToReg_In = 2'b10; #1;
        tick();
        chk("pci_wb", WBData_Out, 32'hDEAD_0004);
        MemToReg_In = 2'b11; #1;
        tick();
        chk("m2r11_wb", WBData_Out, 32'h1234);

        // Byte signed load at 0x103, ack 3 cycles after the request
        idle_in();
        op(1, 0, 2'b10, 2'b01, 5'd5, 32'h103, 32'h0);
        n_stall = 0;
        if (Stall_Out) n_stall++;
        tick();
        chk("lb_req", {31'b0, DMemReq}, 1);
        chk("lb_addr", DMemAddr, 32'h100);
        chk("lb_we", {31'b0, DMemWE}, 0);
        chk("lb_be", {28'b0, DMemByteEn}, 4'b1000);
        chk("lb_rw_bubble", {31'b0, RegWrite_Out}, 0);
        if (Stall_Out) n_stall++;
        tick(); if (Stall_Out) n_stall++;
        tick(); if (Stall_Out) n_stall++;
        tick();
        DMemAck = 1; DMemRData = 32'h80FF_FF00; #1;
        if (Stall_Out) n_stall++;
        chk("lb_stall_cnt", n_stall, 4);
        tick();
        idle_in();
        chk("lb_req_drop", {31'b0, DMemReq}, 0);
        chk("lb_wb", WBData_Out, 32'hFFFF_FF80);
        chk("lb_rw", {31'b0, RegWrite_Out}, 1);
        chk("lb_dst", {27'b0, RegDest_Out}, 5);

        quick_load("lbu", 2'b11, 32'h101, 32'h1234_80AB, 32'h0000_0080);
        quick_load("lh",  2'b01, 32'h102, 32'h8001_0000, 32'hFFFF_8001);
        quick_load("lw",  2'b00, 32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Half store at 0x202
        op(0, 1, 2'b01, 2'b00, 5'd3, 32'h202, 32'hAAAA_BEEF);
        tick();
        chk("sh_we", {31'b0, DMemWE}, 1);
        chk("sh_be", {28'b0, DMemByteEn}, 4'b1100);
        chk("sh_wd", DMemWData, 32'hBEEF_BEEF);
        chk("sh_addr", DMemAddr, 32'h200);
        DMemAck = 1;
        tick();
        idle_in();
        chk("sh_rw", {31'b0, RegWrite_Out}, 0);

        // Byte store at 0x001 and word store (read+write set: treated as store)
        op(0, 1, 2'b10, 2'b00, 5'd3, 32'h001, 32'h1234_565A);
        tick();
        chk("sb_be", {28'b0, DMemByteEn}, 4'b0010);
        chk("sb_wd", DMemWData, 32'h5A5A_5A5A);
        DMemAck = 1; tick(); idle_in();
        op(1, 1, 2'b00, 2'b01, 5'd3, 32'h008, 32'h0BAD_F00D);
        tick();
        chk("sw_we", {31'b0, DMemWE}, 1);
        chk("sw_be", {28'b0, DMemByteEn}, 4'b1111);
        chk("sw_wd", DMemWData, 32'h0BAD_F00D);
        DMemAck = 1; tick(); idle_in();
        chk("sw_rw", {31'b0, RegWrite_Out}, 0);

        // Misaligned word load
        op(1, 0, 2'b00, 2'b01, 5'd4, 32'h101, 32'h0);
        chk("mis_stall", {31'b0, Stall_Out}, 0);
        tick();
        idle_in();
        chk("mis_pulse", {31'b0, MisAlign_Out}, 1);
        chk("mis_rw", {31'b0, RegWrite_Out}, 0);
        chk("mis_req", {31'b0, DMemReq}, 0);
        tick();
        chk("mis_end", {31'b0, MisAlign_Out}, 0);

        // Timeout: no ack ever
        op(1, 0, 2'b00, 2'b01, 5'd6, 32'h300, 32'h0);
        n_stall = 0;
        for (int k = 0; k < 40 && Stall_Out; k++) begin
            n_stall++;
            tick();
        end
        chk("to_stall_cnt", n_stall, 17);
        tick();
        idle_in();
        chk("to_buserr", {31'b0, BusErr_Out}, 1);
        chk("to_req", {31'b0, DMemReq}, 0);
        chk("to_rw", {31'b0, RegWrite_Out}, 0);
        tick();
        chk("to_buserr_end", {31'b0, BusErr_Out}, 0);

        // Reset mid-WAIT, late ack ignored
        op(1, 0, 2'b00, 2'b01, 5'd8, 32'h400, 32'h0);
        tick(); tick();
        idle_in();
        Reset = 0;
        tick(); tick();
        Reset = 1;
        chk("rw_req", {31'b0, DMemReq}, 0);
        chk("rw_be", {28'b0, DMemByteEn}, 0);
        chk("rw_wb", WBData_Out, 0);
        DMemAck = 1; DMemRData = 32'h5555_AAAA;
        tick();
        DMemAck = 0;
        chk("rw_late_rw", {31'b0, RegWrite_Out}, 0);
        chk("rw_late_wb", WBData_Out, 0);
        chk("rw_late_req", {31'b0, DMemReq}, 0);
        chk("rw_stall", {31'b0, Stall_Out}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
